mmcm_lock_sequencer: RTL
========================

# mmcm_lock_sequencer

Reset/lock controller for the clocking MMCM that produces the 25 MHz design clock from the 125 MHz board clock. It runs on the free-running input clock and drives the MMCM RST pin. It watches the MMCM LOCKED output and declares the derived clock ready only after lock has been stable for a set time. On lock loss or lock timeout it re-resets the MMCM, gives up after a bounded number of retries, and reports a fault.

## Interface
- RST_HOLD_CYCLES, 16: cycles the MMCM RST is held high per attempt (≥1)
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before ready (≥1)
- LOCK_TIMEOUT_CYCLES, 125000: cycles in WAIT_LOCK before the attempt fails (1 ms at 125 MHz; > LOCK_STABLE_CYCLES)
- MAX_RETRIES, 3: failed attempts retried before FAULT (≥0)
- clk_in1  in  1  free-running 125 MHz input clock; only clock
- reset_n  in  1  asynchronous, active-low reset
- restart  in  1  synchronous single-cycle request to restart sequencing from any state
- mmcm_locked  in  1  MMCM LOCKED, asynchronous to clk_in1
- mmcm_reset  out  1  to MMCM RST, active-high
- clk_ready  out  1  derived clock is locked and stable
- fault  out  1  retries exhausted
- retry_cnt  out  $clog2(MAX_RETRIES+1)  failed attempts since last lock/restart
- seq_state  out  2  current state encoding
- lock_loss_cnt  out  8  saturating count of lock losses while ready (macro only)

## Operation
- mmcm_locked passes through a 2-flop synchronizer; locked_s is the synchronized value. All decisions use locked_s.
- States and encodings:
  - HOLD (0): mmcm_reset=1. Hold counter runs 0..RST_HOLD_CYCLES-1, then the block moves to WAIT_LOCK. The timeout and stable counters are cleared.
  - WAIT_LOCK (1): mmcm_reset=0. The timeout counter increments every cycle. The stable counter increments while locked_s=1 and clears when locked_s=0.
    - When the stable counter reaches LOCK_STABLE_CYCLES, the block moves to LOCKED.
    - Otherwise, when the timeout counter reaches LOCK_TIMEOUT_CYCLES: if retry_cnt==MAX_RETRIES, move to FAULT; else increment retry_cnt and move to HOLD.
  - LOCKED (2): clk_ready=1 and retry_cnt is cleared on entry. If locked_s=0, move to HOLD (lock loss).
  - FAULT (3): mmcm_reset=1, fault=1. The block stays here until restart or reset_n.
- restart has priority over every transition. It causes HOLD next cycle, clears retry_cnt, all counters and fault. Restart while already in HOLD restarts the hold count.
- If stable completion and timeout occur in the same cycle, lock wins.
- Counter widths: $clog2(param+1). No wrap is possible, because each counter is cleared on every state entry.

## Timing
- Reset values: seq_state=HOLD, mmcm_reset=1, clk_ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0.
- All outputs are registered. mmcm_reset, clk_ready and fault are decoded from the state register, so they change in the same cycle as seq_state.
- After reset_n deasserts, mmcm_reset stays high for exactly RST_HOLD_CYCLES cycles.
- mmcm_locked rising to clk_ready rising takes 2 synchronizer cycles plus LOCK_STABLE_CYCLES cycles, plus 1 cycle for the state register.
- mmcm_locked falling to clk_ready falling takes at most 3 cycles.
- A failed attempt takes RST_HOLD_CYCLES + LOCK_TIMEOUT_CYCLES cycles per retry.
- reset_n asserted mid-operation forces the reset values immediately and asynchronously, including mmcm_reset=1.

## Configuration
- MMCM_SEQ_STATUS_EN defined: lock_loss_cnt port and counter exist. The counter increments on each LOCKED→HOLD lock-loss transition, saturates at 255, and is cleared only by reset_n (restart does not clear it).
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Package mmcm_seq_pkg holds:
  - the state enum (HOLD/WAIT_LOCK/LOCKED/FAULT, encodings 0-3);
  - the default parameter constants;
  - the lock_loss_cnt width constant.
- Sub-module sync_2ff is the parameterless 2-flop synchronizer for mmcm_locked, with async active-low reset to 0. It will be reused for other asynchronous inputs.

## Test plan
All scenarios use RST_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Nominal: release reset_n, then raise mmcm_locked at cycle 10 → mmcm_reset is high for exactly 4 cycles, and clk_ready rises 11 cycles after mmcm_locked, with retry_cnt=0.
- Glitchy lock: in WAIT_LOCK, drive mmcm_locked high 5 cycles, low 1 cycle, then high → the stable count restarts, and clk_ready rises 11 cycles after the final rise.
- Retry then fault: mmcm_locked held low → 3 attempts with retry_cnt stepping 0→1→2, then fault=1, mmcm_reset=1, seq_state=3 after 3×36 cycles. The block stays there until restart.
- Lock loss: from LOCKED, drop mmcm_locked → clk_ready falls within 3 cycles, mmcm_reset pulses 4 cycles, and lock_loss_cnt=1 when the macro is defined.
- Restart priority: pulse restart in the cycle where the timeout fires with retry_cnt=2 → HOLD next cycle, retry_cnt=0, fault stays 0.
- Async reset mid-WAIT_LOCK: assert reset_n low between clock edges → mmcm_reset=1 and all other outputs take their reset values before the next edge.

Source files
------------

// File: rtl/mmcm_seq_pkg.sv
// ----------------------------------------------------------------------------
// mmcm_seq_pkg
// Shared definitions for the MMCM reset/lock sequencer:
//   - seq_state_e     : sequencer state encoding (HOLD/WAIT_LOCK/LOCKED/FAULT)
//   - DEF_*           : default timing/retry parameter values
//   - LOCK_LOSS_CNT_W : width of the optional lock-loss status counter
//   - cnt_width()     : width needed to hold 0..max_val (never less than 1)
// ----------------------------------------------------------------------------
package mmcm_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_FAULT     = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_RST_HOLD_CYCLES     = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 256;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 125000;
    localparam int unsigned DEF_MAX_RETRIES         = 3;

    localparam int unsigned LOCK_LOSS_CNT_W = 8;

    // A zero-retry build would otherwise produce a zero-width retry counter.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level input. Both flops
// reset to 0 asynchronously.
// Ports:
//   i_clk   in  destination clock
//   i_rst_n in  asynchronous active-low reset
//   i_d     in  asynchronous input level
//   o_q     out synchronized level (two destination-clock cycles of latency)
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mmcm_lock_sequencer.sv
// ----------------------------------------------------------------------------
// mmcm_lock_sequencer
// Drives the MMCM RST pin, waits for LOCKED to be stable before declaring the
// derived clock ready, re-resets the MMCM on lock loss or lock timeout, and
// gives up with a fault after MAX_RETRIES failed attempts.
//
// Optional build macro: MMCM_SEQ_STATUS_EN adds the lock_loss_cnt port and
// its saturating counter (cleared only by reset_n).
//
// Ports:
//   clk_in1       in  free-running input clock (only clock)
//   reset_n       in  asynchronous active-low reset
//   restart       in  single-cycle request to restart sequencing
//   mmcm_locked   in  MMCM LOCKED, asynchronous to clk_in1
//   mmcm_reset    out MMCM RST, active-high
//   clk_ready     out derived clock locked and stable
//   fault         out retries exhausted
//   retry_cnt     out failed attempts since last lock/restart
//   seq_state     out current state encoding
//   lock_loss_cnt out saturating lock-loss count (MMCM_SEQ_STATUS_EN only)
// ----------------------------------------------------------------------------
module mmcm_lock_sequencer
    import mmcm_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
    localparam int unsigned RETRY_W            = cnt_width(MAX_RETRIES)
) (
    input  logic               clk_in1,
    input  logic               reset_n,
    input  logic               restart,
    input  logic               mmcm_locked,
    output logic               mmcm_reset,
    output logic               clk_ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [1:0]         seq_state
`ifdef MMCM_SEQ_STATUS_EN
    ,
    output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

    localparam int unsigned HOLD_W   = cnt_width(RST_HOLD_CYCLES);
    localparam int unsigned STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned TMO_W    = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_DONE = STABLE_W'(LOCK_STABLE_CYCLES);
    // The timeout fires in the last cycle of the window so that WAIT_LOCK
    // lasts exactly LOCK_TIMEOUT_CYCLES cycles per failed attempt.
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    seq_state_e          r_state;
    seq_state_e          w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [STABLE_W-1:0] r_stable_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [RETRY_W-1:0]  r_retry_cnt;

    logic w_locked_s;
    logic w_hold_done;
    logic w_stable_done;
    logic w_timeout;
    logic w_stay;
    logic w_mmcm_reset;
    logic w_clk_ready;
    logic w_fault;

    sync_2ff u_lock_sync (
        .i_clk   (clk_in1),
        .i_rst_n (reset_n),
        .i_d     (mmcm_locked),
        .o_q     (w_locked_s)
    );

    assign w_hold_done   = (r_hold_cnt == HOLD_LAST);
    assign w_stable_done = (r_stable_cnt == STABLE_DONE);
    assign w_timeout     = (r_tmo_cnt == TMO_LAST);

    // Counters only advance while the FSM stays put; any state entry,
    // including a restart into HOLD, starts them from zero.
    assign w_stay = !restart && (w_state_nxt == r_state);

    always_ff @(posedge clk_in1 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = ST_HOLD;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_hold_done) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock completion is checked first so it wins a tie
                    // with the timeout.
                    if (w_stable_done) begin
                        w_state_nxt = ST_LOCKED;
                    end else if (w_timeout) begin
                        w_state_nxt = (r_retry_cnt == RETRY_MAX) ? ST_FAULT : ST_HOLD;
                    end
                end
                ST_LOCKED: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                end
            endcase
        end
    end

    always_comb begin
        w_mmcm_reset = 1'b0;
        w_clk_ready  = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            ST_HOLD: begin
                w_mmcm_reset = 1'b1;
            end
            ST_LOCKED: begin
                w_clk_ready = 1'b1;
            end
            ST_FAULT: begin
                w_mmcm_reset = 1'b1;
                w_fault      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_in1 or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_stable_cnt <= '0;
        end else begin
            r_hold_cnt   <= (w_stay && r_state == ST_HOLD)
                            ? r_hold_cnt + HOLD_W'(1) : '0;
            r_tmo_cnt    <= (w_stay && r_state == ST_WAIT_LOCK)
                            ? r_tmo_cnt + TMO_W'(1) : '0;
            r_stable_cnt <= (w_stay && r_state == ST_WAIT_LOCK && w_locked_s)
                            ? r_stable_cnt + STABLE_W'(1) : '0;
        end
    end

    always_ff @(posedge clk_in1 or negedge reset_n) begin
        if (!reset_n) begin
            r_retry_cnt <= '0;
        end else if (restart) begin
            r_retry_cnt <= '0;
        end else if (r_state == ST_WAIT_LOCK && w_state_nxt == ST_LOCKED) begin
            r_retry_cnt <= '0;
        end else if (r_state == ST_WAIT_LOCK && w_state_nxt == ST_HOLD) begin
            r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
        end
    end

`ifdef MMCM_SEQ_STATUS_EN
    logic [LOCK_LOSS_CNT_W-1:0] r_lock_loss_cnt;

    // Only a genuine LOCKED->HOLD drop counts; a restart out of LOCKED does not.
    always_ff @(posedge clk_in1 or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_loss_cnt <= '0;
        end else if (!restart && r_state == ST_LOCKED && w_state_nxt == ST_HOLD
                     && r_lock_loss_cnt != '1) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + LOCK_LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_cnt = r_lock_loss_cnt;
`endif

    assign mmcm_reset = w_mmcm_reset;
    assign clk_ready  = w_clk_ready;
    assign fault      = w_fault;
    assign retry_cnt  = r_retry_cnt;
    assign seq_state  = r_state;

endmodule
